// File: rtl/jpeg_bitstream_unpacker.sv
// jpeg_bitstream_unpacker: strips 0xFF00 stuffing, detects markers and presents an
// MSB-aligned bit window with variable-length consume to the Huffman decoder.
module jpeg_bitstream_unpacker #(
    parameter int PEEK_W = 16,
    parameter int BUF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [PEEK_W-1:0] peek_data,
    output logic [5:0]        bit_count,
    input  logic              consume_en,
    input  logic [4:0]        consume_len,
    input  logic              align_en,
    output logic              marker_valid,
    output logic [7:0]        marker_code,
    input  logic              marker_ack,
    output logic              err
);
    typedef enum logic [1:0] {NORMAL, GOT_FF, MARKER} state_t;
    localparam logic [5:0] FULL_AT  = 6'(BUF_W - 8);
    localparam logic [5:0] PEEK_MAX = 6'(PEEK_W);
    state_t state, state_next;
    logic [BUF_W-1:0] buffer, buf_shift, buf_align, buf_next;
    logic [5:0] cnt_shift, cnt_align, cnt_next;
    logic accept, clear, do_consume, bad_consume, do_append, got_marker;
    logic [7:0] app_byte;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= NORMAL;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (clear)
            state_next = NORMAL;
        else if (accept && state == NORMAL && in_data == 8'hFF)
            state_next = GOT_FF;
        else if (accept && state == GOT_FF && in_data == 8'h00)
            state_next = NORMAL;
        else if (got_marker)
            state_next = MARKER;
    end
    always_comb begin
        in_ready = (state != MARKER) && (bit_count <= FULL_AT);
    end
    // Datapath order: consume, then align, then append at the resulting count.
    always_comb begin
        accept      = in_valid && in_ready;
        clear       = marker_ack && state == MARKER;
        got_marker  = accept && state == GOT_FF && in_data != 8'h00 && in_data != 8'hFF;
        do_consume  = consume_en && consume_len != 5'd0 && {1'b0, consume_len} <= PEEK_MAX
                      && {1'b0, consume_len} <= bit_count;
        bad_consume = consume_en && !do_consume;
        buf_shift   = do_consume ? buffer << consume_len : buffer;
        cnt_shift   = do_consume ? bit_count - {1'b0, consume_len} : bit_count;
        buf_align   = align_en ? buf_shift << cnt_shift[2:0] : buf_shift;
        cnt_align   = align_en ? {cnt_shift[5:3], 3'b000} : cnt_shift;
        do_append   = accept && ((state == NORMAL && in_data != 8'hFF) ||
                                 (state == GOT_FF && in_data == 8'h00));
        app_byte    = state == GOT_FF ? 8'hFF : in_data;
        buf_next    = do_append ? buf_align | ({app_byte, {(BUF_W-8){1'b0}}} >> cnt_align) : buf_align;
        cnt_next    = do_append ? cnt_align + 6'd8 : cnt_align;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer       <= '0;
            bit_count    <= '0;
            marker_valid <= 1'b0;
            marker_code  <= 8'h00;
            err          <= 1'b0;
        end else begin
            buffer       <= clear ? '0 : buf_next;
            bit_count    <= clear ? 6'd0 : cnt_next;
            marker_valid <= clear ? 1'b0 : (got_marker ? 1'b1 : marker_valid);
            marker_code  <= got_marker ? in_data : marker_code;
            err          <= err | bad_consume;
        end
    end
    assign peek_data = buffer[BUF_W-1 -: PEEK_W];
endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// tb_jpeg_bitstream_unpacker: table-driven directed vectors plus hand-written
// sequences for reset-in-GOT_FF and consume/marker_ack collision.
module tb_jpeg_bitstream_unpacker;
    logic        clk, rst, in_valid, in_ready, consume_en, align_en, marker_valid, marker_ack, err;
    logic [7:0]  in_data, marker_code;
    logic [15:0] peek_data;
    logic [5:0]  bit_count;
    logic [4:0]  consume_len;
    int checks = 0, failures = 0;

    jpeg_bitstream_unpacker #(.PEEK_W(16), .BUF_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .peek_data(peek_data), .bit_count(bit_count), .consume_en(consume_en),
        .consume_len(consume_len), .align_en(align_en), .marker_valid(marker_valid),
        .marker_code(marker_code), .marker_ack(marker_ack), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bit_count > 6'd32) begin
            failures++;
            $display("FAIL overflow bit_count=%0d limit=32", bit_count);
        end

    typedef struct {
        logic v; logic [7:0] d; logic ce; logic [4:0] cl; logic al; logic ak;
        logic [15:0] ep; logic [5:0] ec; logic er; logic emv; logic [7:0] emc; logic ee;
    } vec_t;
    vec_t tbl[31];

    function automatic vec_t mk(logic v, logic [7:0] d, logic ce, logic [4:0] cl, logic al,
                                logic ak, logic [15:0] ep, logic [5:0] ec, logic er,
                                logic emv, logic [7:0] emc, logic ee);
        vec_t t;
        t.v = v; t.d = d; t.ce = ce; t.cl = cl; t.al = al; t.ak = ak;
        t.ep = ep; t.ec = ec; t.er = er; t.emv = emv; t.emc = emc; t.ee = ee;
        return t;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk(string tag, logic [15:0] ep, logic [5:0] ec, logic er, logic emv,
                       logic [7:0] emc, logic ee);
        cmp({tag, ".peek"}, 32'(peek_data), 32'(ep));
        cmp({tag, ".count"}, 32'(bit_count), 32'(ec));
        cmp({tag, ".ready"}, 32'(in_ready), 32'(er));
        cmp({tag, ".mvalid"}, 32'(marker_valid), 32'(emv));
        cmp({tag, ".mcode"}, 32'(marker_code), 32'(emc));
        cmp({tag, ".err"}, 32'(err), 32'(ee));
    endtask

    task automatic step(logic v, logic [7:0] d, logic ce, logic [4:0] cl, logic al, logic ak);
        in_valid = v; in_data = d; consume_en = ce; consume_len = cl; align_en = al; marker_ack = ak;
        @(posedge clk);
        #1;
        in_valid = 0; consume_en = 0; align_en = 0; marker_ack = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 0; consume_en = 0; consume_len = 0;
        align_en = 0; marker_ack = 0;
        tbl[0]  = mk(1,8'hA5,0, 0,0,0, 16'hA500, 8,1,0,8'h00,0);
        tbl[1]  = mk(1,8'h3C,0, 0,0,0, 16'hA53C,16,1,0,8'h00,0);
        tbl[2]  = mk(0,8'h00,1, 4,0,0, 16'h53C0,12,1,0,8'h00,0);
        tbl[3]  = mk(0,8'h00,1,12,0,0, 16'h0000, 0,1,0,8'h00,0);
        tbl[4]  = mk(1,8'h12,0, 0,0,0, 16'h1200, 8,1,0,8'h00,0);
        tbl[5]  = mk(1,8'hFF,0, 0,0,0, 16'h1200, 8,1,0,8'h00,0);
        tbl[6]  = mk(1,8'h00,0, 0,0,0, 16'h12FF,16,1,0,8'h00,0);
        tbl[7]  = mk(1,8'h34,0, 0,0,0, 16'h12FF,24,1,0,8'h00,0);
        tbl[8]  = mk(0,8'h00,1, 8,0,0, 16'hFF34,16,1,0,8'h00,0);
        tbl[9]  = mk(0,8'h00,1,16,0,0, 16'h0000, 0,1,0,8'h00,0);
        tbl[10] = mk(1,8'h80,0, 0,0,0, 16'h8000, 8,1,0,8'h00,0);
        tbl[11] = mk(1,8'hFF,0, 0,0,0, 16'h8000, 8,1,0,8'h00,0);
        tbl[12] = mk(1,8'hFF,0, 0,0,0, 16'h8000, 8,1,0,8'h00,0);
        tbl[13] = mk(1,8'hD3,0, 0,0,0, 16'h8000, 8,0,1,8'hD3,0);
        tbl[14] = mk(1,8'h55,0, 0,0,0, 16'h8000, 8,0,1,8'hD3,0);
        tbl[15] = mk(1,8'h55,0, 0,0,1, 16'h0000, 0,1,0,8'hD3,0);
        tbl[16] = mk(1,8'h55,0, 0,0,0, 16'h5500, 8,1,0,8'hD3,0);
        tbl[17] = mk(1,8'hB6,0, 0,0,0, 16'h55B6,16,1,0,8'hD3,0);
        tbl[18] = mk(0,8'h00,1, 3,0,0, 16'hADB0,13,1,0,8'hD3,0);
        tbl[19] = mk(0,8'h00,0, 0,1,0, 16'hB600, 8,1,0,8'hD3,0);
        tbl[20] = mk(1,8'h11,0, 0,0,0, 16'hB611,16,1,0,8'hD3,0);
        tbl[21] = mk(1,8'h22,0, 0,0,0, 16'hB611,24,1,0,8'hD3,0);
        tbl[22] = mk(1,8'h33,0, 0,0,0, 16'hB611,32,0,0,8'hD3,0);
        tbl[23] = mk(1,8'h77,1, 8,0,0, 16'h1122,24,1,0,8'hD3,0);
        tbl[24] = mk(1,8'h77,1, 8,0,0, 16'h2233,24,1,0,8'hD3,0);
        tbl[25] = mk(1,8'h88,0, 0,0,0, 16'h2233,32,0,0,8'hD3,0);
        tbl[26] = mk(0,8'h00,1,16,0,0, 16'h7788,16,1,0,8'hD3,0);
        tbl[27] = mk(0,8'h00,1, 3,1,0, 16'h8800, 8,1,0,8'hD3,0);
        tbl[28] = mk(0,8'h00,1, 9,0,0, 16'h8800, 8,1,0,8'hD3,1);
        tbl[29] = mk(0,8'h00,1, 0,0,0, 16'h8800, 8,1,0,8'hD3,1);
        tbl[30] = mk(0,8'h00,0, 0,0,1, 16'h8800, 8,1,0,8'hD3,1);
        #12;
        chk("reset", 16'h0000, 0, 1, 0, 8'h00, 0);
        rst = 0;
        for (int i = 0; i < 31; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].ce, tbl[i].cl, tbl[i].al, tbl[i].ak);
            chk($sformatf("vec%0d", i), tbl[i].ep, tbl[i].ec, tbl[i].er, tbl[i].emv, tbl[i].emc, tbl[i].ee);
        end
        // Async reset while a 0xFF is pending in GOT_FF with 20 bits buffered.
        rst = 1; #1; rst = 0;
        step(1, 8'hAA, 0, 0, 0, 0);
        step(1, 8'hBB, 0, 0, 0, 0);
        step(1, 8'hCC, 0, 0, 0, 0);
        step(0, 8'h00, 1, 4, 0, 0);
        chk("pre_rst", 16'hABBC, 20, 1, 0, 8'h00, 0);
        step(1, 8'hFF, 0, 0, 0, 0);
        chk("got_ff", 16'hABBC, 20, 1, 0, 8'h00, 0);
        rst = 1; #1;
        chk("async_rst", 16'h0000, 0, 1, 0, 8'h00, 0);
        #1; rst = 0;
        step(1, 8'h00, 0, 0, 0, 0);
        chk("post_rst_00", 16'h0000, 8, 1, 0, 8'h00, 0);
        step(1, 8'h12, 0, 0, 0, 0);
        chk("post_rst_12", 16'h0012, 16, 1, 0, 8'h00, 0);
        // Consume inside MARKER, then consume colliding with marker_ack.
        step(1, 8'hFF, 0, 0, 0, 0);
        step(1, 8'hD0, 0, 0, 0, 0);
        chk("mk_d0", 16'h0012, 16, 0, 1, 8'hD0, 0);
        step(0, 8'h00, 1, 4, 0, 0);
        chk("mk_consume", 16'h0120, 12, 0, 1, 8'hD0, 0);
        step(0, 8'h00, 1, 4, 0, 1);
        chk("mk_ack_wins", 16'h0000, 0, 1, 0, 8'hD0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
